// File: rtl/cnn_cell_sequencer.sv
//------------------------------------------------------------------------------
// Module   : cnn_cell_sequencer
// Brief    : Serial template loader and iteration controller for one CNN cell.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cnn_cell_sequencer #(
   parameter int WIDTH = 9,
   parameter int ONE   = 256,
   parameter int ITW   = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_valid,
   input  logic signed [WIDTH-1:0]   cfg_data,
   output logic                      cfg_ready,
   output logic signed [WIDTH-1:0]   coef_a1,
   output logic signed [WIDTH-1:0]   coef_a2,
   output logic signed [WIDTH-1:0]   coef_a3,
   output logic signed [WIDTH-1:0]   coef_a4,
   output logic signed [WIDTH-1:0]   coef_a5,
   output logic signed [WIDTH-1:0]   coef_a6,
   output logic signed [WIDTH-1:0]   coef_a7,
   output logic signed [WIDTH-1:0]   coef_a8,
   output logic signed [WIDTH-1:0]   coef_a9,
   output logic signed [WIDTH-1:0]   coef_b1,
   output logic signed [WIDTH-1:0]   coef_b2,
   output logic signed [WIDTH-1:0]   coef_b3,
   output logic signed [WIDTH-1:0]   coef_b4,
   output logic signed [WIDTH-1:0]   coef_b5,
   output logic signed [WIDTH-1:0]   coef_b6,
   output logic signed [WIDTH-1:0]   coef_b7,
   output logic signed [WIDTH-1:0]   coef_b8,
   output logic signed [WIDTH-1:0]   coef_b9,
   output logic signed [WIDTH-1:0]   coef_i,
   output logic                      tmpl_valid,
   input  logic                      start,
   input  logic [ITW-1:0]            iter_count,
   input  logic signed [2*WIDTH-1:0] x_init,
   input  logic signed [2*WIDTH-1:0] x_next,
   output logic signed [2*WIDTH-1:0] x_state,
   output logic signed [2*WIDTH-1:0] y_out,
   output logic                      busy,
   output logic                      step,
   output logic                      done,
   output logic                      converged,
   output logic                      start_err,
   output logic [ITW-1:0]            iter_idx
);

   localparam int SW    = 2 * WIDTH;
   localparam int NCOEF = 19;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic signed [SW-1:0] SAT_HI = SW'(ONE);
   localparam logic signed [SW-1:0] SAT_LO = SW'(-ONE);
   localparam logic [4:0]           LAST_IDX = 5'(NCOEF - 1);

   logic [1:0]                state_q, state_d;
   logic [4:0]                cfg_idx_q;
   logic signed [WIDTH-1:0]   coef_q [NCOEF];
   logic                      tmpl_valid_q;
   logic signed [SW-1:0]      x_state_q;
   logic signed [SW-1:0]      y_out_q;
   logic [ITW-1:0]            iter_idx_q;
   logic [ITW-1:0]            count_q;
   logic                      converged_q;
   logic                      start_err_q;

   logic                      in_idle;
   logic                      start_ok;
   logic                      run_conv;
   logic                      run_last;
   logic [ITW:0]              idx_inc;

   assign in_idle  = (state_q == S_IDLE);
   assign start_ok = in_idle && start && tmpl_valid_q;
   assign run_conv = (x_next == x_state_q);
   // One bit wider so a count of 2**ITW-1 still compares correctly.
   assign idx_inc  = {1'b0, iter_idx_q} + {{ITW{1'b0}}, 1'b1};
   assign run_last = (idx_inc == {1'b0, count_q});

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start_ok) state_d = (iter_count != '0) ? S_RUN : S_DONE;
         S_RUN:  if (run_conv || run_last) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      cfg_ready = 1'b0;
      busy      = 1'b0;
      step      = 1'b0;
      done      = 1'b0;
      case (state_q)
         S_IDLE: cfg_ready = 1'b1;
         S_RUN: begin
            busy = 1'b1;
            step = 1'b1;
         end
         S_DONE: done = 1'b1;
         default: ;
      endcase
   end

   // Template loader: only accepts words while idle
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_idx_q    <= '0;
         tmpl_valid_q <= 1'b0;
         for (int k = 0; k < NCOEF; k++) coef_q[k] <= '0;
      end else if (in_idle && cfg_valid) begin
         coef_q[cfg_idx_q] <= cfg_data;
         if (cfg_idx_q == '0)      tmpl_valid_q <= 1'b0;
         if (cfg_idx_q == LAST_IDX) begin
            tmpl_valid_q <= 1'b1;
            cfg_idx_q    <= '0;
         end else begin
            cfg_idx_q    <= cfg_idx_q + 5'd1;
         end
      end
   end

   // Iteration datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         x_state_q   <= '0;
         iter_idx_q  <= '0;
         count_q     <= '0;
         converged_q <= 1'b0;
         start_err_q <= 1'b0;
      end else begin
         start_err_q <= in_idle && start && !tmpl_valid_q;
         if (start_ok) begin
            x_state_q   <= x_init;
            iter_idx_q  <= '0;
            count_q     <= iter_count;
            converged_q <= 1'b0;
         end else if (state_q == S_RUN) begin
            x_state_q  <= x_next;
            iter_idx_q <= idx_inc[ITW-1:0];
            if (run_conv) converged_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                   y_out_q <= '0;
      else if (x_state_q > SAT_HI) y_out_q <= SAT_HI;
      else if (x_state_q < SAT_LO) y_out_q <= SAT_LO;
      else                       y_out_q <= x_state_q;
   end

   assign coef_a1 = coef_q[0];
   assign coef_a2 = coef_q[1];
   assign coef_a3 = coef_q[2];
   assign coef_a4 = coef_q[3];
   assign coef_a5 = coef_q[4];
   assign coef_a6 = coef_q[5];
   assign coef_a7 = coef_q[6];
   assign coef_a8 = coef_q[7];
   assign coef_a9 = coef_q[8];
   assign coef_b1 = coef_q[9];
   assign coef_b2 = coef_q[10];
   assign coef_b3 = coef_q[11];
   assign coef_b4 = coef_q[12];
   assign coef_b5 = coef_q[13];
   assign coef_b6 = coef_q[14];
   assign coef_b7 = coef_q[15];
   assign coef_b8 = coef_q[16];
   assign coef_b9 = coef_q[17];
   assign coef_i  = coef_q[18];

   assign tmpl_valid = tmpl_valid_q;
   assign x_state    = x_state_q;
   assign y_out      = y_out_q;
   assign iter_idx   = iter_idx_q;
   assign converged  = converged_q;
   assign start_err  = start_err_q;

endmodule

`default_nettype wire
